// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM generator behind an Avalon-MM slave. Every channel has a
// double-buffered period/duty, output inversion, one-shot mode and a done interrupt.
module pwm_multi_channel #(
    parameter int NUM_CH     = 4,
    parameter int CNT_WIDTH  = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  write,
    input  logic [31:0]           writedata,
    input  logic                  read,
    output logic [31:0]           readdata,
    output logic [NUM_CH-1:0]     pwm_export,
    output logic                  irq
);

    logic [CNT_WIDTH-1:0] shadow_period_r [NUM_CH];
    logic [CNT_WIDTH-1:0] shadow_duty_r   [NUM_CH];
    logic [CNT_WIDTH-1:0] act_period_r    [NUM_CH];
    logic [CNT_WIDTH-1:0] act_duty_r      [NUM_CH];
    logic [CNT_WIDTH-1:0] cnt_r           [NUM_CH];
    logic [3:0]           ctrl_r          [NUM_CH];
    logic [31:0]          ch_rd_s         [NUM_CH];
    logic [NUM_CH-1:0]    done_r;
    logic [NUM_CH-1:0]    pwm_r;
    logic                 irq_r;
    logic [31:0]          readdata_r;

    logic [ADDR_WIDTH-1:0] ch_idx_s;
    logic [1:0]            reg_sel_s;
    logic [NUM_CH-1:0]     sel_s;
    logic [NUM_CH-1:0]     ctrl_wr_s;
    logic [NUM_CH-1:0]     period_wr_s;
    logic [NUM_CH-1:0]     duty_wr_s;
    logic [NUM_CH-1:0]     done_clr_s;
    logic [NUM_CH-1:0]     tc_s;
    logic [NUM_CH-1:0]     oneshot_end_s;
    logic [NUM_CH-1:0]     load_s;
    logic [NUM_CH-1:0]     cnt_clr_s;
    logic [NUM_CH-1:0]     raw_s;
    logic [NUM_CH-1:0]     inv_s;
    logic [NUM_CH-1:0]     irq_src_s;
    logic [31:0]           rd_mux_s;
    logic                  unused_s;

    assign unused_s = ^writedata;

    // Address decode and per-channel control events.
    always_comb begin
        ch_idx_s  = address >> 2;
        reg_sel_s = address[1:0];
        for (int i = 0; i < NUM_CH; i++) begin
            sel_s[i]       = (ch_idx_s == ADDR_WIDTH'(i));
            period_wr_s[i] = write && sel_s[i] && (reg_sel_s == 2'd0);
            duty_wr_s[i]   = write && sel_s[i] && (reg_sel_s == 2'd1);
            ctrl_wr_s[i]   = write && sel_s[i] && (reg_sel_s == 2'd2);
            done_clr_s[i]  = write && sel_s[i] && (reg_sel_s == 2'd3) && writedata[0];
            tc_s[i]        = ctrl_r[i][0] && (act_period_r[i] != CNT_WIDTH'(0)) &&
                             (cnt_r[i] == act_period_r[i] - CNT_WIDTH'(1));
            oneshot_end_s[i] = tc_s[i] && ctrl_r[i][2];
            // Reload on a software enable edge or on a continuous-mode wrap.
            load_s[i]      = (ctrl_wr_s[i] && writedata[0] && !ctrl_r[i][0]) ||
                             (tc_s[i] && !ctrl_r[i][2]);
            cnt_clr_s[i]   = load_s[i] || tc_s[i] || !ctrl_r[i][0] ||
                             (ctrl_wr_s[i] && !writedata[0]) ||
                             (act_period_r[i] == CNT_WIDTH'(0));
            raw_s[i]       = ctrl_r[i][0] && (act_period_r[i] != CNT_WIDTH'(0)) &&
                             (cnt_r[i] < act_duty_r[i]);
            inv_s[i]       = ctrl_r[i][1];
            irq_src_s[i]   = done_r[i] && ctrl_r[i][3];
        end
    end

    // Register read mux; unmatched channel indices fall through to zero.
    always_comb begin
        rd_mux_s = 32'd0;
        for (int i = 0; i < NUM_CH; i++) begin
            case (reg_sel_s)
                2'd0:    ch_rd_s[i] = 32'(shadow_period_r[i]);
                2'd1:    ch_rd_s[i] = 32'(shadow_duty_r[i]);
                2'd2:    ch_rd_s[i] = {28'd0, ctrl_r[i]};
                2'd3:    ch_rd_s[i] = {30'd0, ctrl_r[i][0], done_r[i]};
                default: ch_rd_s[i] = 32'd0;
            endcase
            rd_mux_s = rd_mux_s | (sel_s[i] ? ch_rd_s[i] : 32'd0);
        end
    end

    // Channel state, output, interrupt and read-data registers.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_period_r[i] <= CNT_WIDTH'(0);
                shadow_duty_r[i]   <= CNT_WIDTH'(0);
                act_period_r[i]    <= CNT_WIDTH'(0);
                act_duty_r[i]      <= CNT_WIDTH'(0);
                cnt_r[i]           <= CNT_WIDTH'(0);
                ctrl_r[i]          <= 4'd0;
            end
            done_r     <= {NUM_CH{1'b0}};
            pwm_r      <= {NUM_CH{1'b0}};
            irq_r      <= 1'b0;
            readdata_r <= 32'd0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (period_wr_s[i]) begin
                    shadow_period_r[i] <= writedata[CNT_WIDTH-1:0];
                end
                if (duty_wr_s[i]) begin
                    shadow_duty_r[i] <= writedata[CNT_WIDTH-1:0];
                end
                // A software CTRL write overrides the one-shot auto-clear.
                if (ctrl_wr_s[i]) begin
                    ctrl_r[i] <= writedata[3:0];
                end else if (oneshot_end_s[i]) begin
                    ctrl_r[i][0] <= 1'b0;
                end
                if (oneshot_end_s[i]) begin
                    done_r[i] <= 1'b1;
                end else if (done_clr_s[i]) begin
                    done_r[i] <= 1'b0;
                end
                if (load_s[i]) begin
                    act_period_r[i] <= shadow_period_r[i];
                    act_duty_r[i]   <= shadow_duty_r[i];
                end
                if (cnt_clr_s[i]) begin
                    cnt_r[i] <= CNT_WIDTH'(0);
                end else begin
                    cnt_r[i] <= cnt_r[i] + CNT_WIDTH'(1);
                end
            end
            pwm_r <= raw_s ^ inv_s;
            irq_r <= |irq_src_s;
            if (read) begin
                readdata_r <= rd_mux_s;
            end
        end
    end

    assign readdata   = readdata_r;
    assign pwm_export = pwm_r;
    assign irq        = irq_r;

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Self-checking bench for pwm_multi_channel: register table, directed waveform
// sequences, collisions and randomized configurations against a waveform model.
module tb_pwm_multi_channel;

    logic        clk;
    logic        reset_reset;
    logic [3:0]  address;
    logic        write;
    logic [31:0] writedata;
    logic        read;
    logic [31:0] readdata;
    logic [3:0]  pwm_export;
    logic        irq;
    logic [31:0] readdata2;
    logic [1:0]  pwm2;
    logic        irq2;

    int total_checks = 0;
    int passed_checks = 0;

    pwm_multi_channel #(.NUM_CH(4), .CNT_WIDTH(16), .ADDR_WIDTH(4)) u_dut (
        .clk_clk(clk), .reset_reset(reset_reset), .address(address), .write(write),
        .writedata(writedata), .read(read), .readdata(readdata),
        .pwm_export(pwm_export), .irq(irq)
    );

    pwm_multi_channel #(.NUM_CH(2), .CNT_WIDTH(16), .ADDR_WIDTH(4)) u_dut2 (
        .clk_clk(clk), .reset_reset(reset_reset), .address(address), .write(write),
        .writedata(writedata), .read(read), .readdata(readdata2),
        .pwm_export(pwm2), .irq(irq2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    typedef struct {
        bit          do_wr;
        int          ch;
        int          rg;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            passed_checks++;
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int ch, input int rg, input logic [31:0] d);
        address = 4'(ch * 4 + rg);
        writedata = d;
        write = 1'b1;
        tick();
        write = 1'b0;
    endtask

    task automatic rd(input int ch, input int rg, output logic [31:0] d);
        address = 4'(ch * 4 + rg);
        read = 1'b1;
        tick();
        read = 1'b0;
        tick();
        d = readdata;
    endtask

    // Expected output k cycles after the enabling write edge (k >= 1).
    function automatic bit model_pwm(int k, int p, int d, bit inv, bit oneshot);
        bit act;
        if (p == 0) act = 1'b0;
        else if (oneshot && k > p) act = 1'b0;
        else act = (((k - 1) % p) < d);
        return act ^ inv;
    endfunction

    logic [31:0] rdat;

    initial begin
        vecs[0] = '{1'b1, 0, 0, 32'hFFFF_1234, 32'h0000_1234};
        vecs[1] = '{1'b1, 1, 1, 32'hABCD_0006, 32'h0000_0006};
        vecs[2] = '{1'b1, 2, 2, 32'hFFFF_FFF6, 32'h0000_0006};
        vecs[3] = '{1'b0, 2, 3, 32'h0,         32'h0000_0000};
        vecs[4] = '{1'b1, 3, 2, 32'h0000_0001, 32'h0000_0001};
        vecs[5] = '{1'b0, 3, 3, 32'h0,         32'h0000_0002};
        vecs[6] = '{1'b1, 3, 3, 32'hFFFF_FFFF, 32'h0000_0002};
        vecs[7] = '{1'b1, 3, 2, 32'h0000_0000, 32'h0000_0000};

        reset_reset = 1'b1; address = 4'd0; write = 1'b0; writedata = 32'd0; read = 1'b0;
        tick(); tick();
        reset_reset = 1'b0;

        check("reset_pwm", 32'(pwm_export), 32'd0);
        check("reset_irq", 32'(irq), 32'd0);
        check("reset_readdata", readdata, 32'd0);
        for (int a = 0; a < 16; a++) begin
            rd(a / 4, a % 4, rdat);
            check($sformatf("reset_read_%0d", a), rdat, 32'd0);
        end

        // Register table: optional write, then read back.
        for (int v = 0; v < 8; v++) begin
            if (vecs[v].do_wr) wr(vecs[v].ch, vecs[v].rg, vecs[v].wdata);
            rd(vecs[v].ch, vecs[v].rg, rdat);
            check($sformatf("table_%0d", v), rdat, vecs[v].exp);
        end
        wr(2, 2, 32'd0);

        // ch0 continuous 10/3.
        wr(0, 0, 32'd10); wr(0, 1, 32'd3); wr(0, 2, 32'd1);
        for (int k = 1; k <= 30; k++) begin
            tick();
            check($sformatf("ch0_wave_k%0d", k), 32'(pwm_export[0]), 32'(model_pwm(k, 10, 3, 1'b0, 1'b0)));
        end

        // ch1 8/2 with duty changed to 6 mid-period.
        wr(1, 0, 32'd8); wr(1, 1, 32'd2); wr(1, 2, 32'd1);
        for (int k = 1; k <= 24; k++) begin
            if (k == 4) begin
                address = 4'(1 * 4 + 1); writedata = 32'd6; write = 1'b1;
            end
            tick();
            write = 1'b0;
            check($sformatf("ch1_shadow_k%0d", k), 32'(pwm_export[1]),
                  32'((k <= 8) ? ((k - 1) < 2) : (((k - 9) % 8) < 6)));
        end

        // ch2 one-shot, inverted, interrupt enabled.
        wr(2, 0, 32'd5); wr(2, 1, 32'd5); wr(2, 2, 32'hF);
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("ch2_oneshot_k%0d", k), 32'(pwm_export[2]), 32'(model_pwm(k, 5, 5, 1'b1, 1'b1)));
            check($sformatf("ch2_irq_k%0d", k), 32'(irq), 32'(k >= 6));
        end
        rd(2, 3, rdat);
        check("ch2_status", rdat, 32'h1);
        wr(2, 3, 32'd1);
        tick();
        check("ch2_irq_cleared", 32'(irq), 32'd0);

        // ch3 boundaries: period 0, duty >= period, duty 0.
        wr(3, 2, 32'd0); wr(3, 0, 32'd0); wr(3, 1, 32'd3); wr(3, 2, 32'd1);
        for (int k = 1; k <= 10; k++) begin
            tick();
            check($sformatf("ch3_p0_k%0d", k), 32'(pwm_export[3]), 32'd0);
        end
        rd(3, 3, rdat);
        check("ch3_p0_status", rdat, 32'h2);
        wr(3, 2, 32'd0); wr(3, 0, 32'd4); wr(3, 1, 32'd9); wr(3, 2, 32'd1);
        for (int k = 1; k <= 12; k++) begin
            tick();
            check($sformatf("ch3_full_k%0d", k), 32'(pwm_export[3]), 32'd1);
        end
        wr(3, 1, 32'd0);
        repeat (6) tick();
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("ch3_zero_k%0d", k), 32'(pwm_export[3]), 32'd0);
        end

        // Randomized configurations on ch0.
        for (int it = 0; it < 20; it++) begin
            int p, d;
            bit inv, os, ie;
            p = $urandom_range(1, 12);
            d = $urandom_range(0, 14);
            inv = 1'($urandom_range(0, 1));
            os = 1'($urandom_range(0, 1));
            ie = 1'($urandom_range(0, 1));
            wr(0, 2, 32'd0); wr(0, 3, 32'd1);
            wr(0, 0, 32'(p)); wr(0, 1, 32'(d));
            wr(0, 2, {28'd0, ie, os, inv, 1'b1});
            for (int k = 1; k <= (os ? p + 3 : 2 * p + 2); k++) begin
                tick();
                check($sformatf("rand%0d_p%0d_d%0d_k%0d", it, p, d, k),
                      32'(pwm_export[0]), 32'(model_pwm(k, p, d, inv, os)));
            end
            rd(0, 3, rdat);
            check($sformatf("rand%0d_status", it), rdat, os ? 32'h1 : 32'h2);
            check($sformatf("rand%0d_irq", it), 32'(irq), 32'(os && ie));
        end
        wr(0, 2, 32'd0); wr(0, 3, 32'd1);

        // W1C in the same cycle as a one-shot terminal count: set wins.
        wr(2, 2, 32'd0); wr(2, 3, 32'd1); wr(2, 0, 32'd3); wr(2, 1, 32'd1); wr(2, 2, 32'hD);
        tick(); tick();
        address = 4'(2 * 4 + 3); writedata = 32'd1; write = 1'b1;
        tick();
        write = 1'b0;
        rd(2, 3, rdat);
        check("collide_w1c_done", rdat, 32'h1);

        // CTRL write in the same cycle as the one-shot auto-clear: write wins.
        wr(2, 2, 32'd0); wr(2, 3, 32'd1); wr(2, 2, 32'hD);
        tick(); tick();
        address = 4'(2 * 4 + 2); writedata = 32'hD; write = 1'b1;
        tick();
        write = 1'b0;
        rd(2, 3, rdat);
        check("collide_ctrl_status", rdat, 32'h3);

        // Reset mid-operation.
        wr(3, 2, 32'h2);
        tick();
        check("pre_reset_pwm3", 32'(pwm_export[3]), 32'd1);
        check("pre_reset_irq", 32'(irq), 32'd1);
        reset_reset = 1'b1;
        tick();
        reset_reset = 1'b0;
        check("reset_mid_pwm", 32'(pwm_export), 32'd0);
        check("reset_mid_irq", 32'(irq), 32'd0);
        check("reset_mid_readdata", readdata, 32'd0);
        rd(2, 2, rdat);
        check("reset_mid_ctrl2", rdat, 32'd0);

        // Channel index beyond NUM_CH on the two-channel instance.
        wr(3, 0, 32'd7); wr(3, 2, 32'h2);
        tick();
        rd(3, 0, rdat);
        check("oor_dut1_period", rdat, 32'd7);
        check("oor_dut2_period", readdata2, 32'd0);
        rd(3, 2, rdat);
        check("oor_dut2_ctrl", readdata2, 32'd0);
        check("oor_dut2_pwm", 32'(pwm2), 32'd0);
        check("oor_dut2_irq", 32'(irq2), 32'd0);
        wr(1, 0, 32'd9);
        rd(1, 0, rdat);
        check("inrange_dut2_period", readdata2, 32'd9);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule

// File: doc/pwm_multi_channel.md
# pwm_multi_channel

- Parametrised successor to the single-channel piezo PWM PIO: NUM_CH independent PWM generators behind one Avalon-MM slave.
- Each channel has programmable period and duty, output polarity, continuous or one-shot mode, and a done interrupt.
- Period/duty updates are double-buffered so waveforms never glitch.
- Sits on the Nios system interconnect; the `pwm_export` bits drive piezo, LED dimming and similar pins.

## Interface
Parameters:
- NUM_CH, 4, number of channels (1..16)
- CNT_WIDTH, 16, width of period/duty/counter (1..32)
- ADDR_WIDTH, 4, word address width; must satisfy 4*NUM_CH <= 2^ADDR_WIDTH

Ports:
- clk_clk  in  1  system clock; single clock domain
- reset_reset  in  1  reset; synchronous, active-high
- address  in  ADDR_WIDTH  word address; channel = address[ADDR_WIDTH-1:2], register = address[1:0]
- write  in  1  write strobe, one cycle per access
- writedata  in  32  write data
- read  in  1  read strobe
- readdata  out  32  read data; fixed read latency 1
- pwm_export  out  NUM_CH  registered PWM outputs
- irq  out  1  level interrupt

## Operation
Register map per channel (reg = address[1:0]):
- 0 PERIOD: write sets the shadow period `[CNT_WIDTH-1:0]`; read returns the shadow value.
- 1 DUTY: write sets the shadow duty; read returns the shadow value.
- 2 CTRL, read/write:
  - bit0 EN: enable
  - bit1 INV: invert output
  - bit2 ONESHOT: stop after one period
  - bit3 IRQEN: interrupt enable
- 3 STATUS:
  - bit0 DONE: write 1 to clear
  - bit1 RUN: read-only, equals EN
- Upper bits of every register read 0 and ignore writes.
- Accesses to a channel index >= NUM_CH are ignored on write and read 0.

Per-channel state: cnt, act_period, act_duty, and the registered output.
- Load event: EN rises (0->1 by write), or terminal count (cnt == act_period-1) while EN=1. On a load event: act_period <= shadow period, act_duty <= shadow duty, cnt <= 0.
- Otherwise, while EN=1, cnt increments each cycle.
- While EN=0, cnt holds at 0.
- Raw level = EN && (cnt < act_duty); `pwm_export` = raw ^ INV, registered.
- Disabled channel outputs INV (idle inactive level).

Boundary rules:
- act_period = 0: output held inactive, cnt held at 0, no terminal count, DONE never sets.
- act_duty = 0: output always inactive.
- act_duty >= act_period: output always active.
- ONESHOT=1: at the first terminal count, EN clears to 0 (hardware write to CTRL.EN), DONE sets, and no reload occurs.
- ONESHOT=0: DONE is never set.
- DONE set and a software W1C in the same cycle: set wins.
- Software write to CTRL in the same cycle as a one-shot auto-clear: the software write wins.
- Writing EN=0 mid-period stops immediately. Output goes to the idle level on the next edge, and cnt resets to 0.
- irq = OR over channels of (DONE & IRQEN), registered.

## Timing
- Reset values: all registers, counters and DONE are 0; pwm_export = 0, irq = 0, readdata = 0.
- Reset asserted mid-operation returns everything to these values on the next edge.
- Read: address sampled with read at edge N; readdata is valid after edge N+1. readdata holds its last value when read=0.
- Write: takes effect at the sampling edge.
- Enable: EN write at edge E0 performs a load at E0 (cnt=0). pwm_export reflects cnt=0 after E1, so the output lags cnt by one cycle.
- Waveform: period is exactly act_period cycles; output is active for exactly min(act_duty, act_period) cycles per period.
- Shadow write mid-period takes effect at the next terminal-count reload only; the current period is unaffected.
- One-shot: DONE and EN=0 are visible at the terminal-count edge; irq asserts one edge later.
- The last active pwm_export cycle precedes the idle level by the one-cycle output lag.

## Test plan
- Reset, then read all 16 words of ch0..ch3 -> every readdata = 0; pwm_export = 4'b0000; irq = 0.
- ch0: PERIOD=10, DUTY=3, CTRL=1 -> pwm_export[0] high 3 cycles, low 7, repeating. First high cycle is 1 cycle after the EN write edge.
- ch1 running with PERIOD=8, DUTY=2; write DUTY=6 at cnt=3:
  - current period keeps 2 high cycles;
  - next period has 6 high cycles;
  - no glitch.
- ch2: PERIOD=5, DUTY=5, CTRL=0xF (EN, INV, ONESHOT, IRQEN):
  - output low for 5 cycles, then high (idle, inverted);
  - STATUS reads 0x1;
  - irq = 1 one edge after DONE;
  - W1C to STATUS -> irq = 0.
- Edge values:
  - ch3 PERIOD=0, CTRL=1 -> output constant 0, DONE stays 0;
  - PERIOD=4, DUTY=9 -> constant 1;
  - DUTY=0 -> constant 0.
- Collisions:
  - W1C on STATUS in the same cycle as a one-shot terminal count -> DONE = 1;
  - assert reset_reset mid-period -> all outputs 0 next edge;
  - write to channel index 3 with NUM_CH=2 -> ignored, reads 0.
